au_seq_param: RTL and testbench
===============================

# au_seq_param

Parametrised, multi-cycle unsigned arithmetic unit. Performs add, subtract, multiply and divide on WIDTH-bit operands behind a start/done handshake. Add/sub complete in one cycle; multiply uses iterative shift-add and divide uses restoring division, one bit per clock. It is the datapath's arithmetic execute stage: registered results, a zero flag and a divide-by-zero flag.

## Interface
- WIDTH, 32, operand and result width; legal range 4..64.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; accepted only when busy=0.
- ALUop  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled on the accepting edge.
- a  input  WIDTH  operand A (dividend for DIV); sampled on the accepting edge.
- b  input  WIDTH  operand B (divisor for DIV); sampled on the accepting edge.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- s  output  WIDTH  add/sub result, modulo 2^WIDTH.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.
- zero  output  1  last completed result was zero.
- dbz  output  1  last completed operation was DIV with b=0.
- ovf  output  1  overflow flag; see Configuration.

## Operation
- States: IDLE, MUL, DIV. Iteration counter counts 0..WIDTH-1.
- IDLE, start=1:
  - ALUop 00/01: s <= a+b or a-b. done=1 next cycle. State stays IDLE.
  - ALUop 10: latch a and b. Clear the 2*WIDTH accumulator. Go to MUL.
  - ALUop 11 with b≠0: latch a and b. Clear the partial remainder. Go to DIV.
  - ALUop 11 with b=0: no iteration. Next cycle hi <= a, lo <= all ones, dbz=1, done=1.
- MUL: each cycle, if multiplier LSB=1 add the multiplicand into the upper half, then shift the accumulator right one bit (carry kept). After WIDTH iterations: {hi,lo} <= product, done=1, return to IDLE.
- DIV: each cycle, shift {remainder, dividend} left one bit and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit; otherwise restore. After WIDTH iterations: hi <= remainder, lo <= quotient, done=1, return to IDLE.
- Outputs update only on completion:
  - add/sub updates s; hi and lo hold.
  - mul/div updates hi and lo; s holds.
- zero is updated with every done:
  - ADD/SUB: zero = (s==0).
  - MUL/DIV: zero = (hi==0 && lo==0).
  - DBZ case: zero = 0.
- dbz clears on the next completed operation.
- start while busy=1 is ignored; there is no queueing. a, b and ALUop changes during busy have no effect.
- Unknown state encodings go to IDLE.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, counter 0; busy, done, zero, dbz, ovf = 0; s, hi, lo = 0.
- Reset mid-operation aborts the operation: no done pulse, outputs take reset values.
- Take the accepting edge as edge 0.
- ADD/SUB and DBZ: done high in cycle 1. busy never asserts.
- MUL/DIV:
  - busy high in cycles 1..WIDTH.
  - done high in cycle WIDTH+1 with busy=0. Latency is WIDTH+1.
- A start in a done cycle is accepted (busy=0), so operations can run back-to-back.
- done never stays high two cycles for one operation. Two consecutive add/sub starts give done on consecutive cycles.

## Configuration
- AU_OVF_EN defined: ovf updates with every done.
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (a<b).
  - MUL: hi≠0.
  - DIV: 0.
- AU_OVF_EN undefined: ovf port present, tied to 0. No carry or borrow logic is built.

## Test plan
- WIDTH=32, ADD a=0xFFFFFFFF b=1 -> cycle 1: done=1, s=0, zero=1; ovf=1 if AU_OVF_EN, else 0.
- WIDTH=32, SUB a=5 b=7 -> cycle 1: s=0xFFFFFFFE, zero=0; ovf=1 if AU_OVF_EN.
- WIDTH=8, MUL a=0xFF b=0xFF -> busy cycles 1..8; cycle 9: done=1, hi=0xFE, lo=0x01.
- WIDTH=8, DIV a=100 b=7 -> cycle 9: lo=14, hi=2, dbz=0. Then DIV a=9 b=0 -> done next cycle, hi=9, lo=0xFF, dbz=1, zero=0.
- WIDTH=32, MUL started; second start with ALUop=00 at cycle 5 -> ignored; single done at cycle 33; s unchanged.
- WIDTH=16, DIV started; rst_n=0 at cycle 6 -> busy=0 and all outputs 0 from next cycle; no done pulse. A new ADD is then accepted normally.

Source files
------------

// File: rtl/au_seq_param.sv
// rtl/au_seq_param.sv - multi-cycle unsigned add/sub/mul/div execute stage
//
// Parameter:
//   WIDTH   operand/result width, 4..64
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   request, accepted only while busy=0
//   ALUop   00 ADD, 01 SUB, 10 MUL, 11 DIV (sampled on the accepting edge)
//   a, b    operands (dividend / divisor for DIV), sampled on the accepting edge
//   busy    multi-cycle MUL/DIV in progress
//   done    one-cycle completion pulse; results valid from this cycle on
//   s       add/sub result
//   hi, lo  product halves, or remainder / quotient
//   zero    last completed result was zero
//   dbz     last completed operation was DIV by zero
//   ovf     overflow flag
// Build option:
//   AU_OVF_EN  when defined, ovf tracks carry/borrow/product overflow;
//              otherwise ovf is tied to 0 and no carry logic exists.

module au_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             dbz,
    output logic             ovf
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // part_q: upper accumulator half for MUL, partial remainder for DIV.
    logic [WIDTH-1:0] part_q, part_d;
    // op_a_q: multiplicand for MUL; dividend shifting out / quotient shifting in for DIV.
    logic [WIDTH-1:0] op_a_q, op_a_d;
    // op_b_q: multiplier shifting out / product low half shifting in for MUL; divisor for DIV.
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    // ------------------------------------------------------------------
    // Single-cycle add / subtract
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;

`ifdef AU_OVF_EN
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;

    assign add_ext = {1'b0, a} + {1'b0, b};
    // The extra MSB of an unsigned difference is the borrow, i.e. a < b.
    assign sub_ext = {1'b0, a} - {1'b0, b};
    assign add_res = add_ext[WIDTH-1:0];
    assign sub_res = sub_ext[WIDTH-1:0];
`else
    assign add_res = a + b;
    assign sub_res = a - b;
`endif

    // ------------------------------------------------------------------
    // One shift-add multiply step
    // ------------------------------------------------------------------
    // The low product half shares the multiplier register: each step the
    // bit falling off the sum enters at the top as a multiplier bit leaves
    // at the bottom, so after WIDTH steps {part, op_b} is the full product.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    assign mul_sum     = {1'b0, part_q} + (op_b_q[0] ? {1'b0, op_a_q} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], op_b_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    // The shifted remainder is below 2*divisor, so a WIDTH+1 bit difference
    // is enough: its MSB is set exactly when the trial subtract went negative.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fit;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    assign div_shift    = {part_q, op_a_q[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, op_b_q};
    assign div_fit      = ~div_diff[WIDTH];
    assign div_rem_next = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_next = {op_a_q[WIDTH-2:0], div_fit};

    logic cnt_last;
    assign cnt_last = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        s_d     = s_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (ALUop)
                        OP_ADD: begin
                            s_d    = add_res;
                            zero_d = (add_res == '0);
                            dbz_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_SUB: begin
                            s_d    = sub_res;
                            zero_d = (sub_res == '0);
                            dbz_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_MUL: begin
                            op_a_d  = a;
                            op_b_d  = b;
                            part_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end
                        default: begin
                            if (b == '0) begin
                                // Divide by zero finishes at once with fixed results.
                                hi_d   = a;
                                lo_d   = '1;
                                zero_d = 1'b0;
                                dbz_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                op_a_d  = a;
                                op_b_d  = b;
                                part_d  = '0;
                                cnt_d   = '0;
                                state_d = ST_DIV;
                            end
                        end
                    endcase
                end
            end

            ST_MUL: begin
                part_d = mul_hi_next;
                op_b_d = mul_lo_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_last) begin
                    hi_d    = mul_hi_next;
                    lo_d    = mul_lo_next;
                    zero_d  = (mul_hi_next == '0) && (mul_lo_next == '0);
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_DIV: begin
                part_d = div_rem_next;
                op_a_d = div_quo_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_last) begin
                    hi_d    = div_rem_next;
                    lo_d    = div_quo_next;
                    zero_d  = (div_rem_next == '0) && (div_quo_next == '0);
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            s_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            s_q     <= s_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef AU_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == ST_IDLE) && start) begin
            case (ALUop)
                OP_ADD:  ovf_d = add_ext[WIDTH];
                OP_SUB:  ovf_d = sub_ext[WIDTH];
                OP_MUL:  ovf_d = ovf_q;
                default: ovf_d = (b == '0) ? 1'b0 : ovf_q;
            endcase
        end else if ((state_q == ST_MUL) && cnt_last) begin
            ovf_d = (mul_hi_next != '0);
        end else if ((state_q == ST_DIV) && cnt_last) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done = done_q;
    assign s    = s_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign zero = zero_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_au_seq_param.sv
// tb/tb_au_seq_param.sv - directed table-driven bench for au_seq_param (WIDTH 8 and 32)

module tb_au_seq_param;

`ifdef AU_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start8, busy8, done8, zero8, dbz8, ovf8;
    logic [1:0] op8;
    logic [7:0] a8, b8, s8, hi8, lo8;

    logic        start32, busy32, done32, zero32, dbz32, ovf32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, s32, hi32, lo32;

    au_seq_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ALUop(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .s(s8), .hi(hi8), .lo(lo8),
        .zero(zero8), .dbz(dbz8), .ovf(ovf8)
    );

    au_seq_param #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .ALUop(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .s(s32), .hi(hi32), .lo(lo32),
        .zero(zero32), .dbz(dbz32), .ovf(ovf32)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       zero;
        logic       dbz;
        logic       ovf;
    } vec_t;

    vec_t vecs[14];

    // Called at a falling edge; the next rising edge is the accepting edge.
    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
    endtask

    // Samples cycles 1..lat; returns at the falling edge of the done cycle.
    task automatic wait8(input string name, input int lat, input logic multi);
        logic ok = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                if (done8 !== 1'b0 || busy8 !== multi) ok = 1'b0;
            end else begin
                if (done8 !== 1'b1 || busy8 !== 1'b0) ok = 1'b0;
            end
        end
        chk({name, ".handshake"}, ok, 1);
    endtask

    task automatic wait32_one(input string name);
        @(negedge clk);
        chk({name, ".done"}, {busy32, done32}, 2'b01);
    endtask

    initial begin
        vec_t v;
        logic multi;
        int   lat;
        int   n_done;
        int   done_at;
        logic busy_ok;
        logic [31:0] cap_hi, cap_lo;
        logic cap_zero, cap_ovf;

        rst_n = 1'b0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;

        //          op     a      b      s      hi     lo     z     d     o
        vecs[0]  = '{2'b00, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 8'h05, 8'h07, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{2'b10, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'b11, 8'h64, 8'h07, 8'hFE, 8'h02, 8'h0E, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 8'h09, 8'h00, 8'hFE, 8'h09, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 8'h09, 8'h09, 8'h00, 8'h09, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 8'h03, 8'hC8, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 8'h10, 8'h10, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'b00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{2'b01, 8'h0A, 8'h03, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst8.flags", {busy8, done8, zero8, dbz8, ovf8}, 5'b0);
        chk("rst8.data", {s8, hi8, lo8}, 24'h0);
        chk("rst32.flags", {busy32, done32, zero32, dbz32, ovf32}, 5'b0);
        chk("rst32.s", s32, 32'h0);
        chk("rst32.hilo", {hi32, lo32}, 64'h0);
        rst_n = 1'b1;

        // Table-driven vectors, WIDTH=8
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            multi = v.op[1] && !(v.op == 2'b11 && v.b == 8'h00);
            lat = multi ? 9 : 1;
            @(negedge clk);
            issue8(v.op, v.a, v.b);
            wait8($sformatf("v%0d", i), lat, multi);
            chk($sformatf("v%0d.s", i), s8, v.s);
            chk($sformatf("v%0d.hi", i), hi8, v.hi);
            chk($sformatf("v%0d.lo", i), lo8, v.lo);
            chk($sformatf("v%0d.zero", i), zero8, v.zero);
            chk($sformatf("v%0d.dbz", i), dbz8, v.dbz);
            chk($sformatf("v%0d.ovf", i), ovf8, v.ovf & OVF_EN);
            @(negedge clk);
            chk($sformatf("v%0d.pulse", i), done8, 1'b0);
        end

        // WIDTH=32 ADD wrap to zero
        @(negedge clk);
        issue32(2'b00, 32'hFFFF_FFFF, 32'h1);
        wait32_one("add32");
        chk("add32.s", s32, 32'h0);
        chk("add32.zero", zero32, 1'b1);
        chk("add32.ovf", ovf32, OVF_EN);

        // WIDTH=32 SUB with borrow
        @(negedge clk);
        issue32(2'b01, 32'h5, 32'h7);
        wait32_one("sub32");
        chk("sub32.s", s32, 32'hFFFF_FFFE);
        chk("sub32.zero", zero32, 1'b0);
        chk("sub32.ovf", ovf32, OVF_EN);

        // Two consecutive ADD starts give done on consecutive cycles
        @(negedge clk);
        op32 = 2'b00; a32 = 32'd1; b32 = 32'd2; start32 = 1'b1;
        @(posedge clk);
        #1 a32 = 32'd3; b32 = 32'd4;
        @(negedge clk);
        chk("b2b32.c1", {done32, s32}, {1'b1, 32'd3});
        @(posedge clk);
        #1 start32 = 1'b0;
        @(negedge clk);
        chk("b2b32.c2", {done32, s32}, {1'b1, 32'd7});
        @(negedge clk);
        chk("b2b32.c3", done32, 1'b0);

        // WIDTH=32 MUL with an ignored ADD start at cycle 5
        @(negedge clk);
        issue32(2'b10, 32'h1234_5678, 32'h10);
        n_done = 0; done_at = 0; busy_ok = 1'b1;
        cap_hi = '0; cap_lo = '0; cap_zero = 1'b1; cap_ovf = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy32 !== (c <= 32)) busy_ok = 1'b0;
            if (done32 === 1'b1) begin
                n_done++;
                done_at = c;
                cap_hi = hi32; cap_lo = lo32; cap_zero = zero32; cap_ovf = ovf32;
            end
            if (c == 5) begin
                op32 = 2'b00; a32 = 32'd100; b32 = 32'd200; start32 = 1'b1;
            end
            if (c == 6) start32 = 1'b0;
        end
        chk("mul32.busy", busy_ok, 1'b1);
        chk("mul32.ndone", n_done, 1);
        chk("mul32.done_at", done_at, 33);
        chk("mul32.hi", cap_hi, 32'h1);
        chk("mul32.lo", cap_lo, 32'h2345_6780);
        chk("mul32.zero", cap_zero, 1'b0);
        chk("mul32.ovf", cap_ovf, OVF_EN);
        chk("mul32.s_held", s32, 32'd7);

        // WIDTH=8 MUL then DIV started in the MUL done cycle
        @(negedge clk);
        issue8(2'b10, 8'd3, 8'd5);
        wait8("mulb2b", 9, 1'b1);
        chk("mulb2b.hilo", {hi8, lo8}, 16'h000F);
        issue8(2'b11, 8'd15, 8'd4);
        wait8("divb2b", 9, 1'b1);
        chk("divb2b.hilo", {hi8, lo8}, 16'h0303);
        chk("divb2b.zero", zero8, 1'b0);

        // Reset in the middle of a DIV aborts it
        @(negedge clk);
        issue8(2'b11, 8'd200, 8'd3);
        for (int c = 1; c <= 6; c++) @(negedge clk);
        chk("abort.busy_before", busy8, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.flags", {busy8, done8, zero8, dbz8, ovf8}, 5'b0);
        chk("abort.data", {s8, hi8, lo8}, 24'h0);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
        end
        chk("abort.quiet", n_done, 0);
        @(negedge clk);
        issue8(2'b00, 8'd2, 8'd3);
        wait8("post_abort_add", 1, 1'b0);
        chk("post_abort_add.s", s8, 8'd5);
        chk("post_abort_add.zero", zero8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
